mesh_result_reader: RTL

- Reader end of the PE mesh: snapshots the `o_PE` words of all N PEs once the sort/compute schedule finishes.
- Streams them out one per handshake in snake (boustrophedon) order, so the stream is globally sorted.
- Sits between the SQRT_N x SQRT_N PE array and the host/result sink.
- Replaces ad-hoc probing of individual PE outputs.

---
 rtl/mesh_result_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mesh_result_reader.sv
// rtl/mesh_result_reader.sv - snapshots all PE outputs and streams them in snake order.
// Optional ORDER_CHECK_EN adds a sticky flag for non-ascending stream words.
module mesh_result_reader #(
  parameter int N          = 4,
  parameter int SQRT_N     = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [N*DATA_WIDTH-1:0] i_pe_data,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [ADDR_WIDTH-1:0]   o_idx,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_order_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

  state_t                  state;
  logic [N*DATA_WIDTH-1:0] snap;
  logic                    handshake;
  logic [ADDR_WIDTH-1:0]   next_idx;

  // Odd rows are read right-to-left so the row-sorted mesh yields a globally sorted stream.
  function automatic int snake_src(input logic [ADDR_WIDTH-1:0] k);
    int row;
    int col;
    row = int'(k) / SQRT_N;
    col = int'(k) % SQRT_N;
    if (row % 2 == 0) return row * SQRT_N + col;
    else              return row * SQRT_N + (SQRT_N - 1 - col);
  endfunction

  assign handshake = o_valid & i_ready;
  assign next_idx  = o_idx + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      snap    <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_idx   <= '0;
      o_last  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            snap    <= i_pe_data;
            o_data  <= i_pe_data[snake_src('0)*DATA_WIDTH +: DATA_WIDTH];
            o_idx   <= '0;
            o_valid <= 1'b1;
            o_last  <= (LAST_IDX == '0);
            o_busy  <= 1'b1;
            state   <= STREAM;
          end else begin
            o_busy <= 1'b0;
          end
        end
        STREAM: begin
          if (handshake) begin
            if (o_idx == LAST_IDX) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              o_done  <= 1'b1;
              state   <= DONE;
            end else begin
              o_idx  <= next_idx;
              o_data <= snap[snake_src(next_idx)*DATA_WIDTH +: DATA_WIDTH];
              o_last <= (next_idx == LAST_IDX);
            end
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef ORDER_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_word   <= '0;
      o_order_err <= 1'b0;
    end else if (state == IDLE && i_start) begin
      prev_word   <= '0;
      o_order_err <= 1'b0;
    end else if (state == STREAM && handshake) begin
      prev_word <= o_data;
      if (o_idx != '0 && o_data < prev_word) o_order_err <= 1'b1;
    end
  end
`else
  assign o_order_err = 1'b0;
`endif

endmodule
